// File: rtl/board_lock_engine.sv
// Lock engine: writes a landed piece into the occupancy board,
// clears full rows bottom-up and counts cleared lines.
module board_lock_engine #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lock_valid,
    output logic            lock_ready,
    input  logic [19:0]     lock_cols,
    input  logic [19:0]     lock_rows,
    input  logic            clear_all,
    input  logic [4:0]      rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            done,
    output logic            lock_err,
    output logic [2:0]      lines_this,
    output logic [15:0]     lines_total
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [4:0] ROW_LIM  = 5'(ROWS);
    localparam logic [4:0] COL_LIM  = 5'(COLS);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    state_t          state;
    state_t          state_next;
    logic [COLS-1:0] board [ROWS];
    logic [19:0]     cols_q;
    logic [19:0]     rows_q;
    logic [1:0]      k;
    logic [4:0]      r;
    logic [4:0]      m;
    logic [4:0]      cell_col;
    logic [4:0]      cell_row;
    logic [COLS-1:0] cell_mask;
    logic            cell_in_range;
    logic            cell_busy;
    logic            row_full;

    assign lock_ready = (state == S_IDLE);
    assign done       = (state == S_DONE);
    assign row_full   = &board[r];

    // Current cell selected by k from the captured lock request
    always_comb begin
        cell_col = cols_q[4:0];
        cell_row = rows_q[4:0];
        unique case (k)
            2'd0: begin
                cell_col = cols_q[4:0];
                cell_row = rows_q[4:0];
            end
            2'd1: begin
                cell_col = cols_q[9:5];
                cell_row = rows_q[9:5];
            end
            2'd2: begin
                cell_col = cols_q[14:10];
                cell_row = rows_q[14:10];
            end
            default: begin
                cell_col = cols_q[19:15];
                cell_row = rows_q[19:15];
            end
        endcase
        cell_in_range = (cell_col < COL_LIM) && (cell_row < ROW_LIM);
        cell_mask     = COLS'(1) << cell_col;
        cell_busy     = 1'b0;
        if (cell_in_range) begin
            cell_busy = |(board[cell_row] & cell_mask);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (lock_valid) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (k == 2'd3) state_next = S_SCAN;
            end
            S_SCAN: begin
                if (row_full)       state_next = S_SHIFT;
                else if (r == 5'd0) state_next = S_DONE;
            end
            S_SHIFT: begin
                if (m <= 5'd1) state_next = S_SCAN;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                board[i] <= '0;
            end
            rd_data     <= '0;
            lock_err    <= 1'b0;
            lines_this  <= 3'd0;
            lines_total <= 16'd0;
            cols_q      <= '0;
            rows_q      <= '0;
            k           <= 2'd0;
            r           <= 5'd0;
            m           <= 5'd0;
        end else begin
            rd_data <= (rd_row < ROW_LIM) ? board[rd_row] : '0;
            unique case (state)
                S_IDLE: begin
                    if (lock_valid) begin
                        cols_q     <= lock_cols;
                        rows_q     <= lock_rows;
                        lock_err   <= 1'b0;
                        lines_this <= 3'd0;
                        k          <= 2'd0;
                    end else if (clear_all) begin
                        for (int i = 0; i < ROWS; i++) begin
                            board[i] <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    if (!cell_in_range || cell_busy) begin
                        lock_err <= 1'b1;
                    end else begin
                        board[cell_row] <= board[cell_row] | cell_mask;
                    end
                    k <= k + 2'd1;
                    if (k == 2'd3) r <= ROW_LAST;
                end
                S_SCAN: begin
                    if (row_full) begin
                        lines_this  <= lines_this + 3'd1;
                        lines_total <= lines_total + 16'd1;
                        m           <= r;
                    end else if (r != 5'd0) begin
                        r <= r - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // Row 0 has nothing above it, so it is refilled with zeros
                    if (m == 5'd0) begin
                        board[0] <= '0;
                    end else begin
                        board[m] <= board[m - 5'd1];
                        if (m == 5'd1) board[0] <= '0;
                        m <= m - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_lock_engine.sv
// Directed bench for board_lock_engine: vector table of locks
// plus hand sequences for handshake, clear and reset corners.
module tb_board_lock_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock_valid = 1'b0;
    logic        lock_ready;
    logic [19:0] lock_cols = '0;
    logic [19:0] lock_rows = '0;
    logic        clear_all = 1'b0;
    logic [4:0]  rd_row = '0;
    logic [9:0]  rd_data;
    logic        done;
    logic        lock_err;
    logic [2:0]  lines_this;
    logic [15:0] lines_total;

    int total = 0;
    int bad = 0;

    board_lock_engine dut (
        .clk(clk),
        .rst_n(rst_n),
        .lock_valid(lock_valid),
        .lock_ready(lock_ready),
        .lock_cols(lock_cols),
        .lock_rows(lock_rows),
        .clear_all(clear_all),
        .rd_row(rd_row),
        .rd_data(rd_data),
        .done(done),
        .lock_err(lock_err),
        .lines_this(lines_this),
        .lines_total(lines_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [19:0] cols;
        logic [19:0] rows;
        logic        err;
        logic [2:0]  lines;
        int          lat;
        logic [4:0]  ra;
        logic [9:0]  da;
        logic [4:0]  rb;
        logic [9:0]  db;
    } vec_t;

    function automatic logic [19:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string name, input logic [4:0] row,
                            input logic [9:0] exp);
        rd_row = row;
        tick();
        chk(name, {22'd0, rd_data}, {22'd0, exp});
    endtask

    task automatic count_nonzero(output int nz);
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            rd_row = 5'(i);
            tick();
            if (rd_data !== 10'd0) nz++;
        end
    endtask

    task automatic clear_board();
        int nz;
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        count_nonzero(nz);
        chk("clear_rows", nz, 0);
    endtask

    // Leaves the bench at cycle 1 after the acceptance edge
    task automatic start_lock(input logic [19:0] c, input logic [19:0] r);
        int n;
        n = 0;
        while (lock_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, lock_ready}, 1);
        lock_cols  = c;
        lock_rows  = r;
        lock_valid = 1'b1;
        tick();
        lock_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (done !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        vec_t vecs[14];
        int   cyc;
        int   nz;
        int   tot_exp;

        vecs[0]  = '{1'b0, pk(4,5,4,5), pk(18,18,19,19), 1'b0, 3'd0, 25,
                     5'd18, 10'h030, 5'd19, 10'h030};
        vecs[1]  = '{1'b1, pk(0,1,2,3), pk(19,19,19,19), 1'b0, 3'd0, 25,
                     5'd19, 10'h00F, 5'd18, 10'h000};
        vecs[2]  = '{1'b0, pk(4,5,6,7), pk(19,19,19,19), 1'b0, 3'd0, 25,
                     5'd19, 10'h0FF, 5'd18, 10'h000};
        vecs[3]  = '{1'b0, pk(8,9,8,9), pk(19,19,18,18), 1'b0, 3'd1, 45,
                     5'd19, 10'h300, 5'd18, 10'h000};
        vecs[4]  = '{1'b0, pk(0,0,10,1), pk(5,5,3,5), 1'b1, 3'd0, 25,
                     5'd5, 10'h003, 5'd3, 10'h000};
        vecs[5]  = '{1'b0, pk(0,1,2,3), pk(10,10,10,10), 1'b0, 3'd0, 25,
                     5'd10, 10'h00F, 5'd5, 10'h003};
        vecs[6]  = '{1'b1, pk(0,1,2,3), pk(19,19,19,19), 1'b0, 3'd0, 25,
                     5'd19, 10'h00F, 5'd18, 10'h000};
        vecs[7]  = '{1'b0, pk(4,5,6,7), pk(19,19,19,19), 1'b0, 3'd0, 25,
                     5'd19, 10'h0FF, 5'd18, 10'h000};
        vecs[8]  = '{1'b0, pk(0,1,2,3), pk(18,18,18,18), 1'b0, 3'd0, 25,
                     5'd18, 10'h00F, 5'd19, 10'h0FF};
        vecs[9]  = '{1'b0, pk(4,5,6,7), pk(18,18,18,18), 1'b0, 3'd0, 25,
                     5'd18, 10'h0FF, 5'd19, 10'h0FF};
        vecs[10] = '{1'b0, pk(8,9,8,9), pk(19,19,18,18), 1'b0, 3'd2, 65,
                     5'd19, 10'h000, 5'd18, 10'h000};
        vecs[11] = '{1'b0, pk(0,1,2,3), pk(0,0,0,0), 1'b0, 3'd0, 25,
                     5'd0, 10'h00F, 5'd1, 10'h000};
        vecs[12] = '{1'b0, pk(4,5,6,7), pk(0,0,0,0), 1'b0, 3'd0, 25,
                     5'd0, 10'h0FF, 5'd1, 10'h000};
        vecs[13] = '{1'b0, pk(8,9,8,9), pk(0,0,1,1), 1'b0, 3'd1, 27,
                     5'd0, 10'h000, 5'd1, 10'h300};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, lock_ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, lock_err}, 0);
        chk("rst_lines", {29'd0, lines_this}, 0);
        chk("rst_total", {16'd0, lines_total}, 0);
        count_nonzero(nz);
        chk("rst_rows", nz, 0);

        tot_exp = 0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].clr) clear_board();
            start_lock(vecs[i].cols, vecs[i].rows);
            wait_done(1, cyc);
            chk($sformatf("v%0d_lat", i), cyc, vecs[i].lat);
            chk($sformatf("v%0d_err", i), {31'd0, lock_err},
                {31'd0, vecs[i].err});
            chk($sformatf("v%0d_lines", i), {29'd0, lines_this},
                {29'd0, vecs[i].lines});
            tot_exp += int'(vecs[i].lines);
            chk($sformatf("v%0d_total", i), {16'd0, lines_total}, tot_exp);
            tick();
            chk($sformatf("v%0d_idle", i), {30'd0, lock_ready, done}, 2);
            read_chk($sformatf("v%0d_rowa", i), vecs[i].ra, vecs[i].da);
            read_chk($sformatf("v%0d_rowb", i), vecs[i].rb, vecs[i].db);
        end

        read_chk("rd_oob20", 5'd20, 10'h000);
        read_chk("rd_oob31", 5'd31, 10'h000);

        // lock_valid held high: second acceptance at the end of cycle 26
        nz = 0;
        lock_cols  = pk(0,1,2,3);
        lock_rows  = pk(2,2,2,2);
        lock_valid = 1'b1;
        tick();
        for (int c = 1; c <= 52; c++) begin
            if (lock_ready !== (c == 26 || c == 52)) nz++;
            if (done !== (c == 25 || c == 51)) nz++;
            if (c == 27) lock_valid = 1'b0;
            if (c == 51) chk("hs_dup_err", {31'd0, lock_err}, 1);
            tick();
        end
        chk("hs_pattern", nz, 0);
        read_chk("hs_row2", 5'd2, 10'h00F);

        // clear_all while scanning must not touch the board
        start_lock(pk(0,1,2,3), pk(7,7,7,7));
        repeat (9) tick();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        wait_done(11, cyc);
        chk("scan_clr_lat", cyc, 25);
        read_chk("scan_clr_row7", 5'd7, 10'h00F);
        read_chk("scan_clr_row2", 5'd2, 10'h00F);

        // reset in the middle of a row shift
        clear_board();
        start_lock(pk(0,1,2,3), pk(19,19,19,19));
        wait_done(1, cyc);
        start_lock(pk(4,5,6,7), pk(19,19,19,19));
        wait_done(1, cyc);
        start_lock(pk(8,9,8,9), pk(19,19,18,18));
        repeat (9) tick();
        chk("shift_total", {16'd0, lines_total}, tot_exp + 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("shift_rst_ready", {31'd0, lock_ready}, 1);
        chk("shift_rst_done", {31'd0, done}, 0);
        nz = 0;
        repeat (40) begin
            tick();
            if (done !== 1'b0) nz++;
        end
        chk("shift_rst_nodone", nz, 0);
        chk("shift_rst_total", {16'd0, lines_total}, 0);
        read_chk("shift_rst_row19", 5'd19, 10'h000);
        read_chk("shift_rst_row18", 5'd18, 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
